// File: rtl/fifo_pkt_reader.sv
// Read-side packet engine: pulls one framed packet from the ingress fifo into SRAM and emits a descriptor.
// Build macro PKT_LEN_CHECK_EN additionally flags packets whose header length field disagrees with words written.
module fifo_pkt_reader #(
  parameter int fifo_data_width      = 16,
  parameter int fifo_num_of_priority = 8,
  parameter int fifo_length          = 32,
  parameter int sram_addr_width      = 10,
  localparam int PRIO_W = $clog2(fifo_num_of_priority),
  localparam int LEN_W  = $clog2(fifo_length + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ready,
  input  logic                       sop,
  input  logic                       vld,
  input  logic                       eop,
  input  logic [fifo_data_width-1:0] out_data,
  output logic                       next_data,
  input  logic                       space_ok,
  output logic                       sram_we,
  output logic [sram_addr_width-1:0] sram_addr,
  output logic [fifo_data_width-1:0] sram_wdata,
  output logic                       desc_vld,
  output logic [PRIO_W-1:0]          desc_prio,
  output logic [sram_addr_width-1:0] desc_start,
  output logic [LEN_W-1:0]           desc_len,
  output logic                       desc_err,
  output logic                       busy
);

  typedef enum logic [2:0] {IDLE, REQ, HDR, DATA, DRAIN, DONE} state_t;

  state_t                     state;
  logic [sram_addr_width-1:0] wptr;
  logic [sram_addr_width-1:0] start;
  logic [PRIO_W-1:0]          prio;
  logic [LEN_W-1:0]           cnt;
  logic                       err;
`ifdef PKT_LEN_CHECK_EN
  logic [LEN_W-1:0]           hdr_len;
`endif
  logic                       word_in;
  logic                       close;
  logic                       close_err;

  assign word_in = vld && !eop;
  // A stray sop in DATA ends the current packet exactly like eop does.
  assign close   = ((state == DATA || state == DRAIN) && eop) || (state == DATA && sop);

  assign next_data = (state inside {REQ, HDR, DATA, DRAIN}) && !close;
  assign busy      = (state != IDLE);

  always_comb begin
    close_err = err || (state == DATA && sop && !eop);
`ifdef PKT_LEN_CHECK_EN
    if (hdr_len != cnt) close_err = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wptr       <= '0;
      start      <= '0;
      prio       <= '0;
      cnt        <= '0;
      err        <= 1'b0;
`ifdef PKT_LEN_CHECK_EN
      hdr_len    <= '0;
`endif
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      desc_vld   <= 1'b0;
      desc_prio  <= '0;
      desc_start <= '0;
      desc_len   <= '0;
      desc_err   <= 1'b0;
    end else begin
      sram_we  <= 1'b0;
      desc_vld <= 1'b0;
      case (state)
        IDLE: if (ready && space_ok) state <= REQ;
        REQ:  if (sop) state <= HDR;
        HDR: begin
          if (eop) begin
            desc_vld   <= 1'b1;
            desc_prio  <= '0;
            desc_start <= wptr;
            desc_len   <= '0;
            desc_err   <= 1'b1;
            state      <= DONE;
          end else if (vld) begin
            sram_we    <= 1'b1;
            sram_addr  <= wptr;
            sram_wdata <= out_data;
            start      <= wptr;
            wptr       <= wptr + 1'b1;
            prio       <= out_data[PRIO_W-1:0];
`ifdef PKT_LEN_CHECK_EN
            hdr_len    <= out_data[PRIO_W +: LEN_W];
`endif
            cnt        <= LEN_W'(1);
            err        <= 1'b0;
            state      <= DATA;
          end
        end
        DATA, DRAIN: begin
          if (close) begin
            desc_vld   <= 1'b1;
            desc_prio  <= prio;
            desc_start <= start;
            desc_len   <= cnt;
            desc_err   <= close_err;
            state      <= DONE;
          end else if (word_in && state == DATA) begin
            if (cnt == LEN_W'(fifo_length)) begin
              err   <= 1'b1;
              state <= DRAIN;
            end else begin
              sram_we    <= 1'b1;
              sram_addr  <= wptr;
              sram_wdata <= out_data;
              wptr       <= wptr + 1'b1;
              cnt        <= cnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: a behavioural fifo drives framed packets; a packet-level model predicts SRAM writes and descriptors.
module tb_fifo_pkt_reader;
  localparam int AW    = 10;
  localparam int L     = 32;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst, ready, sop, vld, eop, space_ok;
  logic [15:0] out_data;
  logic        next_data, sram_we, desc_vld, desc_err, busy;
  logic [AW-1:0] sram_addr, desc_start;
  logic [15:0] sram_wdata;
  logic [2:0]  desc_prio;
  logic [5:0]  desc_len;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic s; logic v; logic e; logic [15:0] d; } elem_t;
  elem_t       pkt[$];
  logic [25:0] wq[$], ewq[$];
  logic [19:0] dq[$];
  logic        busy_after_desc[$];
  int          mw = 0;
  logic        nd_at_eop, nd_after;

  fifo_pkt_reader #(
    .fifo_data_width(16),
    .fifo_num_of_priority(8),
    .fifo_length(L),
    .sram_addr_width(AW)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready), .sop(sop), .vld(vld), .eop(eop),
    .out_data(out_data), .next_data(next_data), .space_ok(space_ok),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .desc_vld(desc_vld), .desc_prio(desc_prio), .desc_start(desc_start),
    .desc_len(desc_len), .desc_err(desc_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  initial begin : monitor
    logic prev_dv;
    prev_dv = 1'b0;
    forever begin
      @(negedge clk);
      if (sram_we === 1'b1) wq.push_back({sram_addr, sram_wdata});
      if (desc_vld === 1'b1) dq.push_back({desc_prio, desc_start, desc_len, desc_err});
      if (prev_dv) busy_after_desc.push_back(busy);
      prev_dv = (desc_vld === 1'b1);
    end
  end

  function automatic logic [15:0] mk_hdr(input int prio, input int len);
    return {7'($urandom), 6'(len), 3'(prio)};
  endfunction

  // Packet-level model. term: 0 = eop, 1 = closed by a new sop, 2 = empty packet (sop, eop).
  task automatic build_pkt(input logic [15:0] hdr, input int ndata, input int term,
                           output logic [19:0] ed, output logic [19:0] em);
    int nw;
    logic e;
    logic [15:0] w;
    pkt.delete();
    pkt.push_back({1'b1, 1'b0, 1'b0, 16'($urandom)});
    if (term == 2) begin
      pkt.push_back({1'b0, 1'($urandom), 1'b1, 16'($urandom)});
      ed = {3'd0, 10'd0, 6'd0, 1'b1};
      em = {3'd0, 10'd0, 6'h3f, 1'b1};
      return;
    end
    pkt.push_back({1'b0, 1'b1, 1'b0, hdr});
    ewq.push_back({AW'(mw), hdr});
    nw = 1;
    for (int i = 0; i < ndata; i++) begin
      w = 16'($urandom);
      pkt.push_back({1'b0, 1'b1, 1'b0, w});
      if (nw < L) begin
        ewq.push_back({AW'((mw + nw) % DEPTH), w});
        nw++;
      end
    end
    if (term == 1) pkt.push_back({1'b1, 1'b0, 1'b0, 16'($urandom)});
    else           pkt.push_back({1'b0, 1'($urandom), 1'b1, 16'($urandom)});
    e = (ndata + 1 > L) || (term == 1);
`ifdef PKT_LEN_CHECK_EN
    if (int'(hdr[8:3]) != nw) e = 1'b1;
`endif
    ed = {hdr[2:0], AW'(mw), 6'(nw), e};
    em = '1;
    mw = (mw + nw) % DEPTH;
  endtask

  // Behavioural fifo: presents the queued elements once the reader requests, with optional bubbles.
  task automatic drive_pkt(input int bubble_pct, input bit jitter);
    int guard;
    guard = 0;
    while (next_data !== 1'b1) begin
      if (guard == 300) begin
        checks++; errors++;
        $display("FAIL next_data_wait: next_data=%b, required 1 within 300 cycles", next_data);
        return;
      end
      guard++;
      @(negedge clk);
    end
    foreach (pkt[i]) begin
      if (i > 0) begin
        while ($urandom_range(99) < bubble_pct) begin
          sop = 1'b0; vld = 1'b0; eop = 1'b0; out_data = 16'($urandom);
          if (jitter) space_ok = 1'($urandom);
          @(negedge clk);
        end
        if (jitter) space_ok = 1'($urandom);
      end
      sop = pkt[i].s; vld = pkt[i].v; eop = pkt[i].e; out_data = pkt[i].d;
      if (pkt[i].e) begin
        #1;
        nd_at_eop = next_data;
      end
      @(negedge clk);
    end
    sop = 1'b0; vld = 1'b0; eop = 1'b0;
    space_ok = 1'b1;
    nd_after = next_data;
  endtask

  task automatic do_reset();
    rst = 1'b1; sop = 1'b0; vld = 1'b0; eop = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mw = 0;
    wq.delete(); ewq.delete(); dq.delete(); busy_after_desc.delete();
  endtask

  task automatic test_reset();
    logic [54:0] outs;
    repeat (3) @(negedge clk);
    outs = {next_data, sram_we, sram_addr, sram_wdata, desc_vld, desc_prio, desc_start, desc_len, desc_err, busy};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    outs = {next_data, sram_we, sram_addr, sram_wdata, desc_vld, desc_prio, desc_start, desc_len, desc_err, busy};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_idle_outputs: got %h want 0", outs); end
  endtask

  task automatic test_space_ok();
    logic [19:0] ed, em;
    ready = 1'b1; space_ok = 1'b0;
    for (int c = 0; c < 8; c++) begin
      vld = 1'($urandom); out_data = 16'($urandom);
      @(negedge clk);
      checks++;
      if ({next_data, busy, sram_we} !== 3'b000) begin
        errors++; $display("FAIL space_hold[%0d]: next_data,busy,we=%b want 000", c, {next_data, busy, sram_we});
      end
    end
    vld = 1'b0;
    space_ok = 1'b1;
    #1;
    checks++;
    if (next_data !== 1'b0) begin errors++; $display("FAIL space_rise_same: next_data=%b want 0", next_data); end
    @(negedge clk);
    checks++;
    if (next_data !== 1'b1) begin errors++; $display("FAIL space_rise_next: next_data=%b want 1", next_data); end
    build_pkt(mk_hdr(0, 5), 4, 0, ed, em);
    drive_pkt(0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (dq.size() != 1 || (dq[0] & em) !== (ed & em)) begin
      errors++; $display("FAIL space_desc: got n=%0d %h want %h", dq.size(), (dq.size() > 0) ? dq[0] : 20'bx, ed);
    end
  endtask

  task automatic test_basic();
    logic [19:0] ed, em;
    do_reset();
    build_pkt(16'h00F3, 29, 0, ed, em);
    drive_pkt(0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (wq.size() != ewq.size()) begin errors++; $display("FAIL basic_wr_count: got %0d want %0d", wq.size(), ewq.size()); end
    foreach (ewq[i]) begin
      checks++;
      if (i >= wq.size() || wq[i] !== ewq[i]) begin
        errors++; $display("FAIL basic_wr[%0d]: got %h want %h", i, (i < wq.size()) ? wq[i] : 26'bx, ewq[i]);
      end
    end
    checks++;
    if (dq.size() != 1 || dq[0] !== {3'd3, 10'd0, 6'd30, 1'b0}) begin
      errors++; $display("FAIL basic_desc: got n=%0d %h want %h", dq.size(), (dq.size() > 0) ? dq[0] : 20'bx, {3'd3, 10'd0, 6'd30, 1'b0});
    end
    checks++;
    if (nd_at_eop !== 1'b0) begin errors++; $display("FAIL basic_nd_at_eop: got %b want 0", nd_at_eop); end
    checks++;
    if (nd_after !== 1'b0) begin errors++; $display("FAIL basic_nd_after_eop: got %b want 0", nd_after); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] ed0, ed1, em0, em1;
    do_reset();
    build_pkt(mk_hdr(2, 4), 3, 0, ed0, em0);
    drive_pkt(0, 0);
    build_pkt(mk_hdr(7, 4), 3, 0, ed1, em1);
    drive_pkt(0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (wq.size() != ewq.size()) begin errors++; $display("FAIL b2b_wr_count: got %0d want %0d", wq.size(), ewq.size()); end
    foreach (ewq[i]) begin
      checks++;
      if (i >= wq.size() || wq[i] !== ewq[i]) begin
        errors++; $display("FAIL b2b_wr[%0d]: got %h want %h", i, (i < wq.size()) ? wq[i] : 26'bx, ewq[i]);
      end
    end
    checks++;
    if (dq.size() != 2 || (dq[0] & em0) !== (ed0 & em0) || (dq[1] & em1) !== (ed1 & em1)) begin
      errors++; $display("FAIL b2b_desc: got n=%0d %h want %h %h", dq.size(), (dq.size() > 1) ? dq[1] : 20'bx, ed0, ed1);
    end
    checks++;
    if (dq.size() > 1 && dq[1][16:7] !== 10'd4) begin errors++; $display("FAIL b2b_start2: got %0d want 4", dq[1][16:7]); end
    checks++;
    if (busy_after_desc.size() < 1 || busy_after_desc[0] !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_gap: busy after DONE got %b want 0", (busy_after_desc.size() > 0) ? busy_after_desc[0] : 1'bx);
    end
  endtask

  task automatic test_overflow();
    logic [19:0] ed, em;
    wq.delete(); ewq.delete(); dq.delete();
    build_pkt(mk_hdr(6, 32), 34, 0, ed, em);
    drive_pkt(10, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (wq.size() != 32 || ewq.size() != 32) begin errors++; $display("FAIL ovf_wr_count: got %0d want 32", wq.size()); end
    foreach (ewq[i]) begin
      checks++;
      if (i >= wq.size() || wq[i] !== ewq[i]) begin
        errors++; $display("FAIL ovf_wr[%0d]: got %h want %h", i, (i < wq.size()) ? wq[i] : 26'bx, ewq[i]);
      end
    end
    checks++;
    if (dq.size() != 1 || dq[0] !== ed || ed[6:0] !== {6'd32, 1'b1}) begin
      errors++; $display("FAIL ovf_desc: got n=%0d %h want %h", dq.size(), (dq.size() > 0) ? dq[0] : 20'bx, ed);
    end
  endtask

  task automatic test_len_check();
    logic [19:0] ed, em;
    wq.delete(); ewq.delete(); dq.delete();
    build_pkt(mk_hdr(4, 10), 7, 0, ed, em);
    drive_pkt(20, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (dq.size() != 1 || dq[0] !== ed) begin
      errors++; $display("FAIL lencheck_desc: got n=%0d %h want %h", dq.size(), (dq.size() > 0) ? dq[0] : 20'bx, ed);
    end
    checks++;
    if (wq.size() != 8) begin errors++; $display("FAIL lencheck_wr_count: got %0d want 8", wq.size()); end
  endtask

  task automatic test_random();
    logic [19:0] eds[$], ems[$];
    logic [19:0] ed, em;
    int r, term, n, ln;
    wq.delete(); ewq.delete(); dq.delete();
    for (int p = 0; p < 14; p++) begin
      r    = int'($urandom_range(99));
      term = (r < 10) ? 2 : ((r < 25) ? 1 : 0);
      n    = (term == 1) ? int'($urandom_range(20)) : int'($urandom_range(40));
      ln   = ($urandom_range(1) == 1) ? ((n + 1 > L) ? L : n + 1) : int'($urandom_range(L));
      build_pkt(mk_hdr(int'($urandom_range(7)), ln), n, term, ed, em);
      eds.push_back(ed); ems.push_back(em);
      drive_pkt(30, 1);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wq.size() != ewq.size()) begin errors++; $display("FAIL rand_wr_count: got %0d want %0d", wq.size(), ewq.size()); end
    foreach (ewq[i]) begin
      checks++;
      if (i >= wq.size() || wq[i] !== ewq[i]) begin
        errors++; $display("FAIL rand_wr[%0d]: got %h want %h", i, (i < wq.size()) ? wq[i] : 26'bx, ewq[i]);
      end
    end
    checks++;
    if (dq.size() != eds.size()) begin errors++; $display("FAIL rand_desc_count: got %0d want %0d", dq.size(), eds.size()); end
    foreach (eds[i]) begin
      checks++;
      if (i >= dq.size() || (dq[i] & ems[i]) !== (eds[i] & ems[i])) begin
        errors++; $display("FAIL rand_desc[%0d]: got %h want %h mask %h", i, (i < dq.size()) ? dq[i] : 20'bx, eds[i], ems[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [19:0] ed, em;
    int k;
    while (mw != DEPTH - 2) begin
      k = (DEPTH - 2 - mw + DEPTH) % DEPTH;
      if (k > L) k = L;
      build_pkt(mk_hdr(1, k), k - 1, 0, ed, em);
      drive_pkt(0, 0);
    end
    repeat (2) @(negedge clk);
    wq.delete(); ewq.delete(); dq.delete();
    build_pkt(mk_hdr(5, 4), 3, 0, ed, em);
    drive_pkt(10, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (wq.size() != 4) begin errors++; $display("FAIL wrap_wr_count: got %0d want 4", wq.size()); end
    foreach (ewq[i]) begin
      checks++;
      if (i >= wq.size() || wq[i] !== ewq[i]) begin
        errors++; $display("FAIL wrap_wr[%0d]: got %h want %h", i, (i < wq.size()) ? wq[i] : 26'bx, ewq[i]);
      end
    end
    checks++;
    if (dq.size() != 1 || dq[0] !== ed || ed[16:7] !== 10'd1022) begin
      errors++; $display("FAIL wrap_desc: got n=%0d %h want %h", dq.size(), (dq.size() > 0) ? dq[0] : 20'bx, ed);
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] ed, em;
    int guard;
    wq.delete(); ewq.delete(); dq.delete();
    guard = 0;
    while (next_data !== 1'b1 && guard < 50) begin guard++; @(negedge clk); end
    sop = 1'b1; vld = 1'b0; eop = 1'b0;
    @(negedge clk);
    sop = 1'b0; vld = 1'b1; out_data = mk_hdr(2, 6);
    @(negedge clk);
    repeat (3) begin out_data = 16'($urandom); @(negedge clk); end
    vld = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, next_data, sram_we, desc_vld} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_outputs: busy,nd,we,dv=%b want 0000", {busy, next_data, sram_we, desc_vld});
    end
    rst = 1'b0;
    mw = 0;
    wq.delete(); ewq.delete();
    build_pkt(mk_hdr(3, 4), 3, 0, ed, em);
    drive_pkt(0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if (dq.size() != 1 || dq[0] !== ed || ed[16:7] !== 10'd0) begin
      errors++; $display("FAIL rstmid_desc: got n=%0d %h want %h", dq.size(), (dq.size() > 0) ? dq[0] : 20'bx, ed);
    end
    foreach (ewq[i]) begin
      checks++;
      if (i >= wq.size() || wq[i] !== ewq[i]) begin
        errors++; $display("FAIL rstmid_wr[%0d]: got %h want %h", i, (i < wq.size()) ? wq[i] : 26'bx, ewq[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; space_ok = 1'b0;
    sop = 1'b0; vld = 1'b0; eop = 1'b0; out_data = '0;
    nd_at_eop = 1'b1; nd_after = 1'b1;
    test_reset();
    test_space_ok();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_len_check();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
